mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-port unified instruction/data memory between the simpleMIPS fetch unit and the load/store (MEM-stage) unit. Issues at most one memory access at a time, tracks the fixed memory read latency, and routes each response back to the requester that issued it. Data has priority, and a starvation counter guarantees forward progress for fetch. The block sits between `U_fetch`/MEM stage and the memory macro inside `simpleMIPS`.

## Interface
- `AW`, 32, address width (byte address)
- `DW`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4)
- `STARVE_MAX`, 4, consecutive conflicting data wins before fetch is forced (legal 1..15)

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `if_req` in 1 — fetch request, held with `if_addr` until `if_gnt`
- `if_addr` in AW — fetch address
- `if_gnt` out 1 — fetch accepted this cycle (combinational)
- `if_rvalid` out 1 — one-cycle pulse, `if_rdata` valid
- `if_rdata` out DW — instruction word
- `d_req` in 1 — data request, held with `d_*` until `d_gnt`
- `d_we` in 1 — 1 = store, 0 = load
- `d_be` in DW/8 — byte enables (stores)
- `d_addr` in AW, `d_wdata` in DW — data address/write data
- `d_gnt` out 1 — data accepted this cycle (combinational)
- `d_rvalid` out 1 — one-cycle pulse: load data or store ack
- `d_rdata` out DW — load data; 0 on store ack
- `mem_en`, `mem_we` out 1; `mem_be` out DW/8; `mem_addr` out AW; `mem_wdata` out DW — memory command, valid when `mem_en`=1
- `mem_rdata` in DW — valid exactly MEM_LAT cycles after the issuing `mem_en` cycle

## Operation
- States: IDLE (nothing outstanding), WAIT (one access outstanding). Registers: `state`, `owner` (IF/D), `lat_cnt` (2 b), `starve_cnt` (4 b), `owner_we`.
- Issue slot open when state==IDLE, or state==WAIT with lat_cnt==0 (response cycle).
- In an open slot: only one req -> grant it. Both -> grant data unless starve_cnt==STARVE_MAX, then grant fetch.
- Grant cycle: exactly one of `if_gnt`/`d_gnt` =1; `mem_en`=1 and `mem_*` driven from the winner (fetch: `mem_we`=0, `mem_be`=all ones, `mem_wdata`=0). Next state WAIT, `lat_cnt`<=MEM_LAT-1, `owner`<=winner.
- WAIT with lat_cnt>0: decrement; no grant.
- Response cycle (WAIT, lat_cnt==0): pulse owner's rvalid; rdata = `mem_rdata` (0 for store ack). If no new grant, next state IDLE.
- starve_cnt: +1 (saturating at STARVE_MAX) when data granted while `if_req`=1; cleared when fetch granted; otherwise held.
- Non-owner rdata outputs are 0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, starve_cnt 0, lat_cnt 0; all outputs 0, gnt forced 0 while rst=0.
- Grant latency: 0 cycles in an open slot. Response: rvalid at issue cycle + MEM_LAT.
- Throughput: one access per MEM_LAT cycles (MEM_LAT=1: back-to-back, one per cycle).
- Simultaneous response and new grant in the same cycle is required behaviour, not a hazard.
- Reset asserted mid-access: outstanding access dropped, no rvalid after release; first cycle after release is IDLE.
- Deasserting a req before gnt is illegal; behaviour unspecified.

## Structure
- Shared package `mips_mem_pkg`: `owner_t` (OWN_IF, OWN_D), `arb_state_t` (ARB_IDLE, ARB_WAIT), default `MEM_LAT`/`STARVE_MAX` constants.
- One sub-module natural: `arb_prio_sel` (combinational winner select from `if_req`, `d_req`, starve_cnt==STARVE_MAX, slot-open). Counters and FSM stay in the top.

## Test plan
- Reset: hold rst=0 with both reqs high -> all outputs 0; release -> data granted first cycle, `mem_addr`=`d_addr`.
- MEM_LAT=1, fetch-only stream addr 0x0,0x4,0x8 -> `if_gnt` every cycle, `if_rvalid` 1 cycle later with matching `mem_rdata`.
- MEM_LAT=3, load at 0x100 -> `d_gnt` cycle t, `d_rvalid` at t+3, no grants at t+1,t+2 despite `if_req`=1.
- Both reqs held, STARVE_MAX=4, MEM_LAT=1 -> grant pattern D,D,D,D,IF repeating; starve_cnt returns to 0 after IF grant.
- Store d_be=0b0011 at 0x20 -> `mem_we`=1, `mem_be`=0b0011, `d_rvalid` pulse with `d_rdata`=0.
- Assert rst during WAIT (MEM_LAT=3, 1 cycle after grant) -> no `d_rvalid` ever for that access; next request after release granted immediately.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and default constants for the simpleMIPS unified memory port.
package mips_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam int unsigned MEM_LAT_DEFAULT    = 1;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner select: data first unless fetch has been starved to the limit.
module arb_prio_sel
    import mips_mem_pkg::*;
(
    input  logic   slot_open_i,
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  logic   starve_full_i,
    output logic   grant_o,
    output owner_t win_o
);

    always_comb begin
        grant_o = 1'b0;
        win_o   = OWN_D;
        if (slot_open_i) begin
            if (if_req_i && (!d_req_i || starve_full_i)) begin
                grant_o = 1'b1;
                win_o   = OWN_IF;
            end else if (d_req_i) begin
                grant_o = 1'b1;
                win_o   = OWN_D;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [1:0] LAT_RELOAD = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;
    logic [3:0] starve_q, starve_d;
    logic       owner_we_q, owner_we_d;

    logic   slot_open;
    logic   rsp;
    logic   grant;
    owner_t win;

    always_comb begin
        rsp       = (state_q == ARB_WAIT) && (lat_cnt_q == '0);
        // Grants are suppressed while reset is held, since req/gnt is a combinational path.
        slot_open = rst && ((state_q == ARB_IDLE) || (lat_cnt_q == '0));
    end

    arb_prio_sel u_prio_sel (
        .slot_open_i   (slot_open),
        .if_req_i      (if_req),
        .d_req_i       (d_req),
        .starve_full_i (starve_q == STARVE_LIM),
        .grant_o       (grant),
        .win_o         (win)
    );

    always_comb begin
        if_gnt    = grant && (win == OWN_IF);
        d_gnt     = grant && (win == OWN_D);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end

        if_rvalid = rsp && (owner_q == OWN_IF);
        d_rvalid  = rsp && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !owner_we_q) ? mem_rdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        starve_d   = starve_q;
        owner_we_d = owner_we_q;

        // A grant in the response cycle overlaps the new issue with the old return.
        if (grant) begin
            state_d    = ARB_WAIT;
            lat_cnt_d  = LAT_RELOAD;
            owner_d    = win;
            owner_we_d = d_gnt && d_we;
        end else if ((state_q == ARB_WAIT) && (lat_cnt_q != '0)) begin
            lat_cnt_d = lat_cnt_q - 2'd1;
        end else if (rsp) begin
            state_d = ARB_IDLE;
        end

        if (if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            lat_cnt_q  <= '0;
            starve_q   <= '0;
            owner_we_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_cnt_q  <= lat_cnt_d;
            starve_q   <= starve_d;
            owner_we_q <= owner_we_d;
        end
    end

endmodule
